// File: rtl/frc_greyscaler.sv
// FRC dither stage: reduces each colour channel to 1 bit using a frame LFSR
// permuted by a per-pixel spatial hash. Define FRC_FRAME_CHECK_EN to add frame_err.
module frc_greyscaler #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned COMP_W   = 4,
  parameter int unsigned FRC_BITS = 4,
  parameter int unsigned CNT_W    = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH*COMP_W-1:0]   in_pixel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       vsync,
  input  logic [CNT_W-1:0]           cfg_ppl,
  input  logic [CNT_W-1:0]           cfg_lpp,
  input  logic                       cfg_mono,
  input  logic                       cfg_bgr,
  output logic [NUM_CH-1:0]          out_pixel,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef FRC_FRAME_CHECK_EN
  ,
  output logic                       frame_err
`endif
);

  localparam int unsigned F      = FRC_BITS;
  localparam int unsigned POS_W  = 2 * CNT_W;
  localparam int unsigned NSLICE = (POS_W + F - 1) / F;
  localparam int unsigned ROT_W  = $clog2(F);
  localparam int unsigned SH_W   = ROT_W + 1;
  localparam logic [F-1:0] TAP   = (F == 3) ? F'(3'b011) :
                                   (F == 4) ? F'(4'b0011) : F'(5'b00101);

  logic                       s1_valid;
  logic [NUM_CH-1:0][F-1:0]   s1_comp;
  logic [F-1:0]               s1_thr;
  logic [CNT_W-1:0]           col, row;
  logic [F-1:0]               lfsr;
  logic                       vsync_q;

  logic                       s2_adv, s1_adv, accept, vsync_pedge;
  logic [NUM_CH-1:0][F-1:0]   comp_t;
  logic [NUM_CH-1:0]          res, res_pix;
  logic [NSLICE*F-1:0]        pos_pad;
  logic [F-1:0]               hash, thr, lfsr_nxt;
  logic [ROT_W-1:0]           rot;
  logic [SH_W-1:0]            sh_amt;
  logic [2*F-1:0]             rot_sh;

  assign s2_adv      = !out_valid || out_ready;
  assign s1_adv      = !s1_valid || s2_adv;
  assign in_ready    = s1_adv;
  assign accept      = in_valid && s1_adv;
  assign vsync_pedge = vsync && !vsync_q;
  assign lfsr_nxt    = {lfsr[F-2:0], 1'b0} ^ (lfsr[F-1] ? TAP : '0);

  // Channel reorder/truncation and per-channel threshold compare
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int unsigned SW = (c == 0) ? NUM_CH - 1 : ((c == NUM_CH - 1) ? 0 : c);
    assign comp_t[c] = cfg_bgr ? in_pixel[SW*COMP_W + COMP_W - F +: F]
                               : in_pixel[c*COMP_W + COMP_W - F +: F];
    assign res[c]    = (s1_comp[c] >= s1_thr);
  end

  assign res_pix = cfg_mono ? {NUM_CH{res[0]}} : res;

  // Spatial hash: XOR-fold of {row,col} into F-bit slices
  assign pos_pad = (NSLICE*F)'({row, col});
  always_comb begin
    hash = '0;
    for (int s = 0; s < NSLICE; s++) hash = hash ^ pos_pad[s*F +: F];
  end

  // Rotate-left by rot: {lfsr,0} >> (F-rot) splits into the two rotation halves
  assign rot    = ROT_W'(32'(hash) % 32'(F));
  assign sh_amt = SH_W'(F) - SH_W'(rot);
  assign rot_sh = {lfsr, {F{1'b0}}} >> sh_amt;
  assign thr    = rot_sh[2*F-1:F] | rot_sh[F-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_comp   <= '0;
      s1_thr    <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      col       <= '0;
      row       <= '0;
      lfsr      <= F'(1);
      vsync_q   <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (s1_adv) s1_valid <= in_valid;
      if (accept) begin
        s1_comp <= comp_t;
        s1_thr  <= thr;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) out_pixel <= res_pix;
      end
      // Frame re-alignment wins over a same-cycle counter advance
      if (vsync_pedge) begin
        col  <= '0;
        row  <= '0;
        lfsr <= lfsr_nxt;
      end else if (accept) begin
        if (col == cfg_ppl) begin
          col <= '0;
          row <= (row == cfg_lpp) ? '0 : row + CNT_W'(1);
        end else begin
          col <= col + CNT_W'(1);
        end
      end
    end
  end

`ifdef FRC_FRAME_CHECK_EN
  logic wrap_pend;
  logic row_wrap;

  assign row_wrap = accept && (col == cfg_ppl) && (row == cfg_lpp);

  // Sticky error: vsync off-origin, or two frame wraps with no vsync between
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
      wrap_pend <= 1'b0;
    end else if (vsync_pedge) begin
      if ((col != '0) || (row != '0)) frame_err <= 1'b1;
      wrap_pend <= 1'b0;
    end else if (row_wrap) begin
      if (wrap_pend) frame_err <= 1'b1;
      wrap_pend <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_frc_greyscaler.sv
// Scoreboard bench for frc_greyscaler: directed pixels with hand-computed results.
module tb_frc_greyscaler;
  localparam int unsigned NUM_CH = 3, COMP_W = 4, FRC_BITS = 4, CNT_W = 10;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_CH*COMP_W-1:0] in_pixel;
  logic                     in_valid;
  logic                     in_ready;
  logic                     vsync;
  logic [CNT_W-1:0]         cfg_ppl, cfg_lpp;
  logic                     cfg_mono, cfg_bgr;
  logic [NUM_CH-1:0]        out_pixel;
  logic                     out_valid;
  logic                     out_ready;
`ifdef FRC_FRAME_CHECK_EN
  logic                     frame_err;
`endif

  frc_greyscaler #(.NUM_CH(NUM_CH), .COMP_W(COMP_W), .FRC_BITS(FRC_BITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(in_ready), .vsync(vsync), .cfg_ppl(cfg_ppl), .cfg_lpp(cfg_lpp),
    .cfg_mono(cfg_mono), .cfg_bgr(cfg_bgr), .out_pixel(out_pixel),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef FRC_FRAME_CHECK_EN
    , .frame_err(frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec, n_err;
  logic [2:0] sb[$];
  bit         stall_en, ready_off, cnt_en, hold_prev;
  int         ones;
  logic [2:0] prev_pix;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [11:0] pk(input logic [3:0] c2, input logic [3:0] c1, input logic [3:0] c0);
    return {c2, c1, c0};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Present one pixel and record its expected output; returns 2 units after the accepting edge
  task automatic send(input logic [11:0] pix, input logic [2:0] exp);
    int n = 0;
    in_pixel = pix;
    in_valid = 1'b1;
    sb.push_back(exp);
    while (!in_ready && n < 300) begin tick(1); n++; end
    if (n >= 300) chk("accept_timeout", 32'(n), 0);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    tick(1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 600) begin tick(1); n++; end
    chk("drain_empty", 32'(sb.size()), 0);
    tick(2);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    vsync    = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pixel", 32'(out_pixel), 0);
    sb.delete();
    tick(2);
    reset_n = 1'b1;
    tick(1);
    chk("rst_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    logic [14:0] e3;
    logic [31:0] r;
    logic [3:0]  c0, c1, c2;
    n_vec = 0; n_err = 0; ones = 0;
    stall_en = 0; ready_off = 0; cnt_en = 0; hold_prev = 0; prev_pix = '0;
    reset_n = 1'b0; in_pixel = '0; in_valid = 1'b0; vsync = 1'b0;
    cfg_ppl = 10'd3; cfg_lpp = 10'd3; cfg_mono = 1'b0; cfg_bgr = 1'b0;
    out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          hold_prev = 1'b0;
        end else begin
          if (hold_prev) begin
            chk("hold_stable", 32'(out_pixel), 32'(prev_pix));
            chk("hold_valid", 32'(out_valid), 1);
          end
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              chk("unexpected_output", 32'(out_pixel), 32'hFFFF);
            end else begin
              chk("out_pixel", 32'(out_pixel), 32'(sb.pop_front()));
              if (cnt_en) ones += int'(out_pixel[0]);
            end
          end
          hold_prev = out_valid && !out_ready;
          prev_pix  = out_pixel;
        end
      end
      forever begin
        @(posedge clk);
        #1;
        out_ready = ready_off ? 1'b0 : (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
      end
    join_none

    do_reset();

`ifdef FRC_FRAME_CHECK_EN
    // Clean 16-pixel frame, then a short frame
    for (int i = 0; i < 16; i++) send(12'hFFF, 3'b111);
    drain();
    pulse_vsync();
    chk("frame_err_clean", 32'(frame_err), 0);
    for (int i = 0; i < 5; i++) send(12'h000, 3'b000);
    drain();
    pulse_vsync();
    chk("frame_err_short", 32'(frame_err), 1);
    tick(5);
    chk("frame_err_sticky", 32'(frame_err), 1);
    do_reset();
    chk("frame_err_reset", 32'(frame_err), 0);
`endif

    // Latency, ordering and hash-permuted thresholds at lfsr=1
    chk("t1_in_ready0", 32'(in_ready), 1);
    send(pk(4'hF, 4'h0, 4'h1), 3'b101);
    chk("latency_s1", 32'(out_valid), 0);
    chk("t1_in_ready1", 32'(in_ready), 1);
    send(pk(4'h3, 4'h2, 4'h1), 3'b110);
    chk("latency_s2", 32'(out_valid), 1);
    chk("t1_in_ready2", 32'(in_ready), 1);
    send(pk(4'h3, 4'h3, 4'h4), 3'b001);
    chk("t1_in_ready3", 32'(in_ready), 1);
    send(pk(4'h9, 4'h8, 4'h7), 3'b110);
    send(pk(4'hF, 4'h1, 4'h0), 3'b110);
    send(pk(4'h0, 4'h1, 4'h2), 3'b001);
    drain();

    // Saturated inputs over 15 frames
    do_reset();
    for (int f = 0; f < 15; f++) begin
      for (int p = 0; p < 16; p++) begin
        if (p % 2 == 0) send(12'hFFF, 3'b111);
        else            send(12'h000, 3'b000);
      end
      pulse_vsync();
    end
    drain();

    // Temporal duty at (0,0): ch0=5 is 1 in exactly 5 of 15 frames
    do_reset();
    e3 = 15'h0117;
    cnt_en = 1'b1;
    ones = 0;
    for (int f = 0; f < 15; f++) begin
      send(pk(4'h0, 4'hF, 4'h5), {2'b01, e3[f]});
      pulse_vsync();
    end
    drain();
    cnt_en = 1'b0;
    chk("duty_5_of_15", 32'(ones), 5);
    send(pk(4'h0, 4'hF, 4'h1), 3'b011);
    drain();

    // Random backpressure, back-to-back pixels
    do_reset();
    stall_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      r  = $urandom;
      c0 = r[0] ? 4'hF : 4'h0;
      c1 = r[1] ? 4'hF : 4'h0;
      c2 = r[2] ? 4'hF : 4'h0;
      send(pk(c2, c1, c0), r[2:0]);
    end
    drain();
    stall_en = 1'b0;

    // Channel swap and mono
    do_reset();
    cfg_bgr = 1'b1;
    send(pk(4'h0, 4'h0, 4'hF), 3'b100);
    drain();
    cfg_bgr  = 1'b0;
    cfg_mono = 1'b1;
    send(pk(4'h0, 4'h0, 4'hF), 3'b111);
    send(pk(4'hF, 4'hF, 4'h0), 3'b000);
    drain();
    cfg_mono = 1'b0;

    // Reset with a full, stalled pipe drops everything
    do_reset();
    ready_off = 1'b1;
    tick(1);
    send(12'hFFF, 3'b111);
    send(12'h000, 3'b000);
    chk("stall_in_ready", 32'(in_ready), 0);
    tick(3);
    ready_off = 1'b0;
    do_reset();
    tick(3);
    chk("no_ghost_valid", 32'(out_valid), 0);
    send(pk(4'hF, 4'h0, 4'hF), 3'b101);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/frc_greyscaler.md
Name: frc_greyscaler

Overview:
- Parametrised frame-rate-control (FRC) dither stage for the LCD pixel path.
- Sits between the palette/direct-colour unpacker and the STN serialiser.
- Reduces each COMP_W-bit colour channel to 1 bit per channel using a frame LFSR permuted by a per-pixel spatial hash.
- Adds a valid/ready handshake, a 2-stage pipeline, configurable threshold width, and frame re-alignment on vsync.

Parameters:
- NUM_CH, 3, number of colour channels (1..4).
- COMP_W, 4, bits per input channel; must be >= FRC_BITS.
- FRC_BITS, 4, LFSR/threshold width; legal values 3, 4, 5.
- CNT_W, 10, width of the column and row counters.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_pixel  in  NUM_CH*COMP_W  channel c occupies [c*COMP_W +: COMP_W].
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts a pixel when in_valid and in_ready are both high.
- vsync  in  1  frame sync, level; rising edge is significant.
- cfg_ppl  in  CNT_W  pixels per line minus 1.
- cfg_lpp  in  CNT_W  lines per panel minus 1.
- cfg_mono  in  1  1 = all output bits follow channel 0.
- cfg_bgr  in  1  1 = swap channel 0 and channel NUM_CH-1.
- out_pixel  out  NUM_CH  1-bit-per-channel dithered pixel.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid=0, out_pixel=0, internal stage-1 valid=0.
  - col=0, row=0, lfsr=1, vsync register=0.
  - in_ready=1 one cycle after reset release.
- Handshake:
  - Output holds stable while out_valid=1 and out_ready=0.
  - s2 advances when !out_valid or out_ready.
  - s1 advances when !s1_valid or s2 advances.
  - in_ready = !s1_valid or s2 advances. No combinational path from in_valid to in_ready.
- Latency: 2 cycles from acceptance to out_valid under no backpressure. Full throughput is 1 pixel/cycle. No pixel is lost or duplicated under any backpressure pattern.
- Counters (advance on acceptance only):
  - col increments; at col==cfg_ppl, col wraps to 0 and row increments.
  - row wraps to 0 at row==cfg_lpp.
- Frame:
  - vsync_pedge = vsync & !vsync_q.
  - On vsync_pedge: lfsr <= {lfsr[F-2:0],1'b0} ^ (lfsr[F-1] ? TAP : 0), with TAP = 3'b011 / 4'b0011 / 5'b00101 for F = 3 / 4 / 5. The period is 2^F-1 and lfsr never reaches 0.
  - On vsync_pedge, col and row clear to 0. This clear has priority over an increment in the same cycle.
  - A pixel accepted in the vsync_pedge cycle uses the pre-edge col, row and lfsr.
- Stage 1 (registered on accept):
  - Channel reorder per cfg_bgr.
  - Each channel truncated to its top FRC_BITS bits, comp_t.
  - hash = XOR of all FRC_BITS-wide slices of {row,col}; the top slice is zero-padded.
  - thr = lfsr rotated left by (hash mod FRC_BITS). thr lies in [1, 2^F-1].
- Stage 2: out bit c = (comp_t[c] >= thr). When cfg_mono=1, every bit takes channel 0's result.
- Consequences:
  - comp_t=0 always gives 0.
  - comp_t=2^F-1 always gives 1.
  - Over 2^F-1 consecutive frames at a fixed position, the count of 1s equals comp_t.
- cfg_* inputs are sampled live. Software changes them only while vsync is high and the pipe is empty; behaviour otherwise is undefined but must not deadlock.
- Reset asserted mid-frame drops all in-flight pixels and returns every state element to its reset value.

Optional Feature:
- FRC_FRAME_CHECK_EN defined:
  - Adds output frame_err (1 bit, sticky), cleared by reset only.
  - frame_err sets on vsync_pedge when (col,row) != (0,0), meaning an incomplete or over-long frame.
  - frame_err also sets when row wraps without an intervening vsync_pedge.
- FRC_FRAME_CHECK_EN not defined: the port is absent and there is no checking logic.

Test Plan:
- Reset, then 4 pixels with out_ready=1 held: out_valid rises 2 cycles after the first accept; 4 outputs in order; in_ready stays 1.
- F=4, NUM_CH=3, cfg_ppl=3, cfg_lpp=3, every channel 4'hF then 4'h0, over 15 frames: outputs are 3'b111 and 3'b000 respectively in every frame.
- F=4, one fixed pixel with channel 0 = 4'd5, 15 vsync rising edges, position (0,0): channel 0 output is 1 in exactly 5 of 15 frames; lfsr returns to 1 after 15 edges.
- out_ready toggled pseudo-randomly with in_valid=1 for 64 pixels: the output sequence equals the no-stall reference; out_pixel never changes while out_valid=1 and out_ready=0.
- cfg_bgr=1, input ch0=4'hF, ch2=4'h0: out_pixel=3'b100. cfg_mono=1, ch0=4'hF: out_pixel=3'b111.
- FRC_FRAME_CHECK_EN: vsync edge after 5 of 16 pixels (cfg_ppl=3, cfg_lpp=3) gives frame_err=1 the next cycle and it stays set; a clean 16-pixel frame leaves frame_err=0.
